// File: rtl/rom_read_arbiter.sv
// Shares one synchronous EBR ROM between two level-REQ / pulse-ACK readers, round-robin.
// Latency: REQ sampled at E0 -> ACK registered at E(RD_LAT+1); one read per RD_LAT+3 cycles.
// Backpressure: requesters hold REQ/ADDR until ACK; a single outstanding ROM read at a time.
module rom_read_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic          CLK_I,
  input  logic          nRST_I,
  input  logic          REQ0_I,
  input  logic [AW-1:0] ADDR0_I,
  output logic          ACK0_O,
  output logic [DW-1:0] DATA0_O,
  input  logic          REQ1_I,
  input  logic [AW-1:0] ADDR1_I,
  output logic          ACK1_O,
  output logic [DW-1:0] DATA1_O,
  output logic          ROM_CE_O,
  output logic [AW-1:0] ROM_ADDR_O,
  input  logic [DW-1:0] ROM_DATA_I,
  output logic          BUSY_O,
  output logic          GNT_O
);

  // The latency counter and FSM below only make sense for a 1..4 deep ROM pipeline.
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("rom_read_arbiter: RD_LAT must be in 1..4");
  end

  localparam int CW = ($clog2(RD_LAT + 1) < 1) ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ce_q, ce_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            gnt_q, gnt_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic [DW-1:0]   data0_q, data0_d;
  logic [DW-1:0]   data1_q, data1_d;
  logic            busy_q, busy_d;
  logic            any_req;
  logic            win;

  // Round-robin choice: a lone requester wins outright, a tie goes to whoever did not win last.
  always_comb begin
    any_req = REQ0_I | REQ1_I;
    win     = (REQ0_I & REQ1_I) ? ~last_q : REQ1_I;
  end

  // State register; reset abandons any in-flight read and re-arms requester 0 as first winner.
  always_ff @(posedge CLK_I) begin
    if (!nRST_I) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> ISSUE (one cycle) -> WAIT (RD_LAT cycles) -> ACK (one cycle) -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == CW'(1)) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; everything not explicitly loaded holds its last value.
  always_comb begin
    last_d  = last_q;
    cnt_d   = cnt_q;
    ce_d    = 1'b0;
    addr_d  = addr_q;
    gnt_d   = gnt_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    data0_d = data0_q;
    data1_d = data1_q;
    busy_d  = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d  = win;
          last_d = win;
          addr_d = win ? ADDR1_I : ADDR0_I;
          ce_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d = CW'(RD_LAT);
      end
      S_WAIT: begin
        if (cnt_q == CW'(1)) begin
          // ROM data is only trusted on this one edge; the granted port alone is updated.
          if (gnt_q) begin
            data1_d = ROM_DATA_I;
            ack1_d  = 1'b1;
          end else begin
            data0_d = ROM_DATA_I;
            ack0_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and arbitration/latency state.
  always_ff @(posedge CLK_I) begin
    if (!nRST_I) begin
      last_q  <= 1'b1;
      cnt_q   <= '0;
      ce_q    <= 1'b0;
      addr_q  <= '0;
      gnt_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      addr_q  <= addr_d;
      gnt_q   <= gnt_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      busy_q  <= busy_d;
    end
  end

  assign ACK0_O     = ack0_q;
  assign DATA0_O    = data0_q;
  assign ACK1_O     = ack1_q;
  assign DATA1_O    = data1_q;
  assign ROM_CE_O   = ce_q;
  assign ROM_ADDR_O = addr_q;
  assign BUSY_O     = busy_q;
  assign GNT_O      = gnt_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: ROM models return addr^A5 after each instance's latency.
// Main instance RD_LAT=2; two extra instances cover RD_LAT=1 and RD_LAT=4.
// Scoreboard queue holds expected {port,data}; a negedge monitor pops on every ACK.
module tb_rom_read_arbiter;

  localparam int LAT = 2;

  logic clk;
  logic nrst;
  logic req0, req1;
  logic [7:0] addr0, addr1;
  logic ack0, ack1, ce, busy, gnt;
  logic [7:0] data0, data1, rom_addr, rom_data;

  logic sw_r1, sw_r4;
  logic [7:0] sw_addr;
  logic ack0_l1, ack1_l1, ce_l1, busy_l1, gnt_l1;
  logic [7:0] data0_l1, data1_l1, rom_addr_l1, rom_data_l1;
  logic ack0_l4, ack1_l4, ce_l4, busy_l4, gnt_l4;
  logic [7:0] data0_l4, data1_l4, rom_addr_l4, rom_data_l4;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    bit         port;
    logic [7:0] data;
  } exp_t;
  exp_t sbq[$];
  logic [7:0] exp_d0, exp_d1;

  typedef struct {
    bit         r0;
    logic [7:0] a0;
    bit         r1;
    logic [7:0] a1;
    bit         exp_gnt;
    logic [7:0] exp_data;
  } vec_t;

  rom_read_arbiter #(.AW(8), .DW(8), .RD_LAT(LAT)) dut (
    .CLK_I(clk), .nRST_I(nrst),
    .REQ0_I(req0), .ADDR0_I(addr0), .ACK0_O(ack0), .DATA0_O(data0),
    .REQ1_I(req1), .ADDR1_I(addr1), .ACK1_O(ack1), .DATA1_O(data1),
    .ROM_CE_O(ce), .ROM_ADDR_O(rom_addr), .ROM_DATA_I(rom_data),
    .BUSY_O(busy), .GNT_O(gnt)
  );

  rom_read_arbiter #(.AW(8), .DW(8), .RD_LAT(1)) dut_l1 (
    .CLK_I(clk), .nRST_I(nrst),
    .REQ0_I(sw_r1), .ADDR0_I(sw_addr), .ACK0_O(ack0_l1), .DATA0_O(data0_l1),
    .REQ1_I(1'b0), .ADDR1_I(8'h00), .ACK1_O(ack1_l1), .DATA1_O(data1_l1),
    .ROM_CE_O(ce_l1), .ROM_ADDR_O(rom_addr_l1), .ROM_DATA_I(rom_data_l1),
    .BUSY_O(busy_l1), .GNT_O(gnt_l1)
  );

  rom_read_arbiter #(.AW(8), .DW(8), .RD_LAT(4)) dut_l4 (
    .CLK_I(clk), .nRST_I(nrst),
    .REQ0_I(sw_r4), .ADDR0_I(sw_addr), .ACK0_O(ack0_l4), .DATA0_O(data0_l4),
    .REQ1_I(1'b0), .ADDR1_I(8'h00), .ACK1_O(ack1_l4), .DATA1_O(data1_l4),
    .ROM_CE_O(ce_l4), .ROM_ADDR_O(rom_addr_l4), .ROM_DATA_I(rom_data_l4),
    .BUSY_O(busy_l4), .GNT_O(gnt_l4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM models: data valid only RD_LAT edges after the CE edge, junk (EE) otherwise.
  logic [3:0] vp_m = '0, vp_1 = '0, vp_4 = '0;
  logic [7:0] dp_m[4], dp_1[4], dp_4[4];
  always @(posedge clk) begin
    vp_m <= {vp_m[2:0], ce};
    vp_1 <= {vp_1[2:0], ce_l1};
    vp_4 <= {vp_4[2:0], ce_l4};
    dp_m[0] <= rom_addr ^ 8'hA5;
    dp_1[0] <= rom_addr_l1 ^ 8'hA5;
    dp_4[0] <= rom_addr_l4 ^ 8'hA5;
    for (int k = 1; k < 4; k++) begin
      dp_m[k] <= dp_m[k-1];
      dp_1[k] <= dp_1[k-1];
      dp_4[k] <= dp_4[k-1];
    end
  end
  assign rom_data    = vp_m[LAT-1] ? dp_m[LAT-1] : 8'hEE;
  assign rom_data_l1 = vp_1[0] ? dp_1[0] : 8'hEE;
  assign rom_data_l4 = vp_4[3] ? dp_4[3] : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor on the main instance.
  always @(negedge clk) begin
    if (ack0 || ack1) begin
      check("ack_exclusive", {31'd0, ack0 & ack1}, 0);
      check("sb_nonempty", (sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        check("ack_port", {31'd0, ack1}, {31'd0, e.port});
        if (e.port) exp_d1 = e.data;
        else        exp_d0 = e.data;
        check("data0", data0, exp_d0);
        check("data1", data1, exp_d1);
      end
    end
  end

  task automatic do_reset();
    nrst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; sw_r1 = 1'b0; sw_r4 = 1'b0;
    @(negedge clk);
    check("reset_outputs", {ack0, ack1, data0, data1, ce, rom_addr, busy, gnt}, 0);
    exp_d0 = 8'h00;
    exp_d1 = 8'h00;
    nrst = 1'b1;
  endtask

  task automatic wait_ack(inout int n);
    do begin
      @(negedge clk);
      n++;
    end while (!(ack0 || ack1) && n < 30);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    logic [7:0] ea;
    ea = v.exp_gnt ? v.a1 : v.a0;
    req0 = v.r0; addr0 = v.a0; req1 = v.r1; addr1 = v.a1;
    sbq.push_back('{port: v.exp_gnt, data: v.exp_data});
    @(negedge clk);
    n = 1;
    check("issue_ce_busy_gnt_addr", {ce, busy, gnt, rom_addr}, {1'b1, 1'b1, v.exp_gnt, ea});
    @(negedge clk);
    n = 2;
    check("ce_one_cycle", {31'd0, ce}, 0);
    if (!(ack0 || ack1)) wait_ack(n);
    check("ack_latency", n, LAT + 2);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("ack_pulse_then_idle", {ack0, ack1, busy}, 0);
  endtask

  task automatic sweep_read(input bit four, input logic [7:0] a);
    int n;
    int lat;
    logic ak;
    lat = four ? 4 : 1;
    sw_addr = a;
    if (four) sw_r4 = 1'b1; else sw_r1 = 1'b1;
    n = 0;
    ak = 1'b0;
    while (!ak && n < 30) begin
      @(negedge clk);
      n++;
      ak = four ? ack0_l4 : ack0_l1;
    end
    check(four ? "lat4_ack_edge" : "lat1_ack_edge", n, lat + 2);
    check(four ? "lat4_data" : "lat1_data", four ? data0_l4 : data0_l1, a ^ 8'hA5);
    check(four ? "lat4_side" : "lat1_side",
          four ? {busy_l4, gnt_l4, ack1_l4, data1_l4} : {busy_l1, gnt_l1, ack1_l1, data1_l1},
          {1'b1, 1'b0, 1'b0, 8'h00});
    sw_r1 = 1'b0; sw_r4 = 1'b0;
    @(negedge clk);
    check(four ? "lat4_ack_pulse" : "lat1_ack_pulse", {31'd0, four ? ack0_l4 : ack0_l1}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vec_t vr;
    int n, prev;
    vecs[0] = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 8'hB5};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'hA7};
    vecs[2] = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 8'hA4};
    vecs[3] = '{1'b1, 8'h33, 1'b1, 8'h44, 1'b1, 8'hE1};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h80, 1'b1, 8'h25};
    vecs[5] = '{1'b1, 8'hC3, 1'b1, 8'h3C, 1'b0, 8'h66};
    vecs[6] = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h5A};
    vecs[7] = '{1'b1, 8'h12, 1'b1, 8'h34, 1'b1, 8'h91};

    addr0 = 8'h00; addr1 = 8'h00; sw_addr = 8'h00;
    do_reset();

    // Both requesters held after reset: grants 0,1,0,1 spaced LAT+3 cycles.
    req0 = 1'b1; addr0 = 8'h01; req1 = 1'b1; addr1 = 8'h02;
    for (int k = 0; k < 4; k++) sbq.push_back('{port: k[0], data: k[0] ? 8'hA7 : 8'hA4});
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      wait_ack(n);
      if (k == 0) check("rr_first_latency", n, LAT + 2);
      else        check("rr_spacing", cyc - prev, LAT + 3);
      prev = cyc;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    do_reset();
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Address change and REQ drop right after the grant: original read completes.
    req1 = 1'b1; addr1 = 8'h55;
    sbq.push_back('{port: 1'b1, data: 8'hF0});
    @(negedge clk);
    n = 1;
    check("abort_grant_addr", {gnt, rom_addr}, {1'b1, 8'h55});
    req1 = 1'b0; addr1 = 8'hFF;
    wait_ack(n);
    check("abort_ack_latency", n, LAT + 2);
    check("abort_addr_held", {ack1, rom_addr}, {1'b1, 8'h55});
    @(negedge clk);

    // Idle hold: no CE, last values retained.
    for (int k = 0; k < 20; k++) begin
      check("idle_no_ce", {31'd0, ce}, 0);
      @(negedge clk);
    end
    check("idle_hold", {data0, data1, rom_addr, gnt}, {exp_d0, 8'hF0, 8'h55, 1'b1});

    // Reset while in WAIT: no ACK, outputs cleared, requester 0 wins afterwards.
    req0 = 1'b1; addr0 = 8'h20;
    @(negedge clk);
    @(negedge clk);
    check("in_wait_busy", {31'd0, busy}, 1);
    do_reset();
    for (int k = 0; k < 8; k++) begin
      check("post_reset_quiet", {ack0, ack1, busy, ce}, 0);
      @(negedge clk);
    end
    vr = '{1'b1, 8'h06, 1'b1, 8'h07, 1'b0, 8'hA3};
    run_vec(vr);

    // Latency sweep on the RD_LAT=1 and RD_LAT=4 instances.
    sweep_read(1'b0, 8'h5C);
    sweep_read(1'b0, 8'h0F);
    sweep_read(1'b1, 8'h5C);
    sweep_read(1'b1, 8'h0F);

    check("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares one synchronous Lattice MXO2 EBR ROM between two read requesters (requester 0, requester 1).
- Per-requester level REQ/pulse ACK handshake; round-robin arbitration.
- Sequences ROM clock-enable/address and captures data after the ROM's configured read latency.
- Sits between the ROM wrapper and its consumers; exercised under the existing bench_clock generator.

Parameters:
AW, 8, ROM address width
DW, 8, ROM data width
RD_LAT, 2, ROM read latency in cycles (1 = unregistered EBR output, 2 = output register); legal 1..4, elaboration error otherwise

Ports:
CLK_I  input  1  system clock, all logic on rising edge
nRST_I  input  1  Reset is synchronous and active-low.
REQ0_I  input  1  requester 0 read request (level)
ADDR0_I  input  AW  requester 0 address
ACK0_O  output  1  requester 0 one-cycle completion pulse
DATA0_O  output  DW  requester 0 read data, valid when ACK0_O=1, held afterwards
REQ1_I  input  1  requester 1 read request (level)
ADDR1_I  input  AW  requester 1 address
ACK1_O  output  1  requester 1 completion pulse
DATA1_O  output  DW  requester 1 read data
ROM_CE_O  output  1  ROM clock enable, one-cycle pulse per read
ROM_ADDR_O  output  AW  ROM address
ROM_DATA_I  input  DW  ROM read data
BUSY_O  output  1  1 when FSM not in IDLE
GNT_O  output  1  index of current/last granted requester

Behaviour:
- All outputs registered. Reset (nRST_I=0 sampled at an edge): state=IDLE, all outputs 0, round-robin pointer LAST=1 (requester 0 wins first).
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: at edge E0, if any REQ high -> select winner, latch its address into ROM_ADDR_O, set GNT_O, ROM_CE_O=1, go ISSUE. No request -> stay; ROM_CE_O=0.
- Arbitration: only one REQ high -> that one. Both high -> the one != LAST. LAST updated to winner at grant.
- ISSUE: lasts exactly one cycle (ROM samples CE/address at E1). At E1: ROM_CE_O=0, load latency counter with RD_LAT, go WAIT.
- WAIT: counter decrements each edge. At edge E(1+RD_LAT) (counter reaches final count): capture ROM_DATA_I into DATAx_O of granted requester, ACKx_O=1, go ACK. ROM_DATA_I ignored at all other edges.
- ACK: one cycle. ACKx_O high only here, then clears; go IDLE.
- Latency: REQ sampled at E0 -> ACK visible after E(RD_LAT+1), held one cycle. Throughput: back-to-back from a held REQ, one read per RD_LAT+3 cycles.
- Handshake: requester holds REQ and ADDR until ACK, drops REQ within the ACK cycle for a single read. REQ still high when IDLE next samples = new read.
- ADDR changes after grant are ignored (address latched).
- REQ dropped mid-transaction: read completes, ACK still pulses, DATA updated.
- Non-granted DATA/ACK untouched. DATAx_O holds last captured value until that port's next ACK.
- ROM_ADDR_O and GNT_O hold their last value in IDLE.
- ROM_CE_O never high outside ISSUE; at most one outstanding ROM read.
- ACK0_O and ACK1_O never simultaneously high.
- Reset mid-operation (any state): transaction abandoned, no ACK, outputs to reset values on the following cycle, LAST=1.
- Counter width ceil(log2(RD_LAT+1)), minimum 1 bit; no wrap possible.

Test Plan:
- Single read, RD_LAT=2, ROM model data=addr^8'hA5: REQ0=1, ADDR0=8'h10 sampled at E0 -> ROM_CE_O high exactly cycle E0..E1 with ROM_ADDR_O=8'h10; ACK0_O high one cycle after E3 with DATA0_O=8'hB5; BUSY_O high from E0 to end of ACK.
- Simultaneous requests after reset: REQ0 (ADDR 8'h01) and REQ1 (ADDR 8'h02) held -> grants alternate 0,1,0,1; DATA0_O=8'hA4, DATA1_O=8'hA7; ACKs spaced RD_LAT+3=5 cycles; never both ACKs high.
- Parameter sweep RD_LAT=1 and RD_LAT=4: ACK edge = E(RD_LAT+1), i.e. E2 and E5; data matches model with matching pipeline depth.
- Abort/address change: REQ1 dropped and ADDR1 changed to 8'hFF one cycle after grant -> read of original address completes, ACK1_O pulses, DATA1_O=original^8'hA5, ROM_ADDR_O unchanged.
- Reset mid-WAIT: nRST_I=0 for one edge during WAIT -> no ACK, all outputs 0, BUSY_O=0. With both REQ high afterwards, requester 0 granted first.
- Idle hold: no requests for 20 cycles after a read -> ROM_CE_O=0 throughout, DATA0_O/ROM_ADDR_O/GNT_O retain last values.
